generation_scheduler: RTL and testbench
=======================================

// Module: generation_scheduler
// PURPOSE
//  Sequences Game-of-Life generations around double_buffer. Decides when the logic engine starts
//  computing the next generation into the back buffer. Issues the double_buffer swap only at a
//  render frame boundary, so the display never shows a half-written generation.
//  Sits between the vsync source, the logic engine (start/done) and double_buffer.swap_in.
// PARAMETERS
//  GEN_W          16      width of generation counter
//  FRAME_DIV_W    4       width of frames-per-generation input
//  TIMEOUT_CYCLES 1<<20   watchdog limit in clk cycles (used only with GEN_WATCHDOG_EN)
// PORTS
//  clk_in          in   1            system clock, all logic on rising edge
//  rst_in          in   1            asynchronous, active-low reset
//  run_in          in   1            level: free-run, one generation every frame_div_in frames
//  step_in         in   1            pulse: launch exactly one generation (IDLE only)
//  frame_div_in    in   FRAME_DIV_W  frames per generation; 0 treated as 1
//  vsync_in        in   1            1-cycle pulse at each render frame boundary
//  logic_done_in   in   1            1-cycle pulse from logic engine: back buffer fully written
//  logic_start_out out  1            1-cycle pulse: logic engine begins a generation
//  swap_out        out  1            1-cycle pulse to double_buffer.swap_in
//  busy_out        out  1            high in any state other than IDLE
//  gen_count_out   out  GEN_W        number of completed swaps, wraps modulo 2^GEN_W
//  err_out         out  1            sticky watchdog error
// BEHAVIOUR
//  Reset (rst_in=0, async): state=IDLE, frame_cnt=0; all outputs 0, gen_count_out=0.
//  States: IDLE -> COMPUTE -> WAIT_FRAME -> SWAP -> IDLE. All outputs registered.
//  IDLE:
//   - run_in=0: frame_cnt held at 0; vsync_in ignored.
//   - run_in=1 and vsync_in=1:
//     - frame_cnt >= max(frame_div_in,1)-1: launch, frame_cnt<=0.
//     - otherwise frame_cnt++.
//   - step_in=1: launch, regardless of run_in/vsync_in. step_in with a run launch in the same
//     cycle yields a single launch.
//   - launch: next cycle logic_start_out=1 for exactly one cycle, state=COMPUTE.
//  COMPUTE: wait for logic_done_in=1, then go to WAIT_FRAME.
//   - vsync_in in the same cycle as logic_done_in does not count. The swap waits for the next vsync.
//  WAIT_FRAME: on vsync_in=1, go to SWAP.
//  SWAP: swap_out=1 for exactly this one cycle (i.e. the cycle after the vsync pulse).
//   - gen_count_out increments in the same cycle; frame_cnt<=0; next state IDLE.
//  Latency, step_in to logic_start_out: 1 cycle. vsync_in in WAIT_FRAME to swap_out: 1 cycle.
//  step_in outside IDLE: ignored (not queued). logic_done_in outside COMPUTE: ignored.
//  run_in deassertion mid-generation: the current generation completes and swaps; no new launch.
//  gen_count_out wraps 2^GEN_W-1 -> 0.
//  Reset asserted mid-operation: immediately IDLE, swap_out never pulses for the aborted generation.
//  At most one swap_out per vsync_in; never two swaps without an intervening logic_done_in.
// CONFIGURATION
//  GEN_WATCHDOG_EN defined:
//   - cycle counter clears on entering COMPUTE and increments each COMPUTE cycle.
//   - reaching TIMEOUT_CYCLES without logic_done_in: err_out<=1 (sticky until reset), state=IDLE.
//     No swap, gen_count_out unchanged, frame_cnt<=0.
//   - while err_out=1, further launches are still permitted.
//  GEN_WATCHDOG_EN undefined: err_out tied 0; COMPUTE waits indefinitely; TIMEOUT_CYCLES unused.
// TESTING
//  1 reset: rst_in=0 mid-COMPUTE -> all outputs 0 asynchronously, gen_count_out=0, state IDLE.
//  2 single step: step_in pulse at t; done at t+20; vsync at t+40
//    -> logic_start_out at t+1, swap_out at t+41, gen_count_out=1.
//  3 free-run frame_div_in=3, done always before next vsync
//    -> logic_start_out after every 3rd vsync, one swap per generation.
//    -> frame_div_in=0 behaves as 1.
//  4 done and vsync same cycle -> no swap that frame; swap_out the cycle after the following vsync.
//  5 step_in during COMPUTE and WAIT_FRAME -> ignored: exactly one logic_start_out, one swap_out.
//  6 GEN_WATCHDOG_EN, TIMEOUT_CYCLES=16, no done -> err_out=1 after 16 COMPUTE cycles, busy_out=0,
//    no swap_out; next step_in still launches; err_out stays 1.

Source files
------------

// File: rtl/generation_scheduler.sv
// Generation sequencer: launches the logic engine and swaps buffers on frame boundaries.
// Optional compute watchdog enabled by defining GEN_WATCHDOG_EN.
module generation_scheduler #(
   parameter int GEN_W          = 16,
   parameter int FRAME_DIV_W    = 4,
   parameter int TIMEOUT_CYCLES = 1 << 20
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   run_in,
   input  logic                   step_in,
   input  logic [FRAME_DIV_W-1:0] frame_div_in,
   input  logic                   vsync_in,
   input  logic                   logic_done_in,
   output logic                   logic_start_out,
   output logic                   swap_out,
   output logic                   busy_out,
   output logic [GEN_W-1:0]       gen_count_out,
   output logic                   err_out
);

   typedef enum logic [1:0] {
      IDLE,
      COMPUTE,
      WAIT_FRAME,
      SWAP
   } state_t;

   state_t                 state_q, state_d;
   logic [FRAME_DIV_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [FRAME_DIV_W-1:0] div_m1;
   logic [GEN_W-1:0]       gen_q, gen_d;
   logic                   start_q, start_d;
   logic                   swap_q, swap_d;
   logic                   busy_q, busy_d;
   logic                   err_q, err_d;
   logic                   run_hit;

`ifdef GEN_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_q, wd_d;
   logic            timeout;

   assign timeout = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout;

   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

   // A divider of 0 behaves as 1: launch on every vsync.
   assign div_m1  = (frame_div_in == '0) ? '0 : frame_div_in - 1'b1;
   assign run_hit = run_in && vsync_in && (frame_cnt_q >= div_m1);

   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      gen_d       = gen_q;
      err_d       = err_q;
      start_d     = 1'b0;
      swap_d      = 1'b0;
`ifdef GEN_WATCHDOG_EN
      wd_d        = wd_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (!run_in)
               frame_cnt_d = '0;
            else if (vsync_in)
               frame_cnt_d = frame_cnt_q + 1'b1;
            if (run_hit || step_in) begin
               start_d     = 1'b1;
               state_d     = COMPUTE;
               frame_cnt_d = '0;
`ifdef GEN_WATCHDOG_EN
               wd_d        = '0;
`endif
            end
         end
         COMPUTE: begin
            if (logic_done_in) begin
               state_d = WAIT_FRAME;
            end
`ifdef GEN_WATCHDOG_EN
            else if (timeout) begin
               err_d       = 1'b1;
               state_d     = IDLE;
               frame_cnt_d = '0;
            end else begin
               wd_d = wd_q + 1'b1;
            end
`endif
         end
         WAIT_FRAME: begin
            // Only a vsync seen here counts; one coinciding with done is ignored.
            if (vsync_in) begin
               state_d = SWAP;
               swap_d  = 1'b1;
               gen_d   = gen_q + 1'b1;
            end
         end
         SWAP: begin
            state_d     = IDLE;
            frame_cnt_d = '0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q     <= IDLE;
         frame_cnt_q <= '0;
         gen_q       <= '0;
         start_q     <= 1'b0;
         swap_q      <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         frame_cnt_q <= frame_cnt_d;
         gen_q       <= gen_d;
         start_q     <= start_d;
         swap_q      <= swap_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
      end
   end

`ifdef GEN_WATCHDOG_EN
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in)
         wd_q <= '0;
      else
         wd_q <= wd_d;
   end
`endif

   assign logic_start_out = start_q;
   assign swap_out        = swap_q;
   assign busy_out        = busy_q;
   assign gen_count_out   = gen_q;
   assign err_out         = err_q;

endmodule

// File: tb/tb_generation_scheduler.sv
// Directed bench for generation_scheduler.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_generation_scheduler;

   localparam int GW = 4;

   logic          clk_in        = 1'b0;
   logic          rst_in        = 1'b0;
   logic          run_in        = 1'b0;
   logic          step_in       = 1'b0;
   logic          vsync_in      = 1'b0;
   logic          logic_done_in = 1'b0;
   logic [3:0]    frame_div_in  = 4'd3;
   logic          logic_start_out;
   logic          swap_out;
   logic          busy_out;
   logic          err_out;
   logic [GW-1:0] gen_count_out;

   int vectors     = 0;
   int miscompares = 0;

   generation_scheduler #(
      .GEN_W          (GW),
      .FRAME_DIV_W    (4),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .run_in          (run_in),
      .step_in         (step_in),
      .frame_div_in    (frame_div_in),
      .vsync_in        (vsync_in),
      .logic_done_in   (logic_done_in),
      .logic_start_out (logic_start_out),
      .swap_out        (swap_out),
      .busy_out        (busy_out),
      .gen_count_out   (gen_count_out),
      .err_out         (err_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic st, input logic vs, input logic dn);
      step_in       = st;
      vsync_in      = vs;
      logic_done_in = dn;
      @(posedge clk_in);
      #1;
      step_in       = 1'b0;
      vsync_in      = 1'b0;
      logic_done_in = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 1'b0, 1'b0);
   endtask

   task automatic outs(input string tag, input logic st, input logic sw,
                       input logic bz, input logic [31:0] g);
      chk({tag, "_start"}, 32'(logic_start_out), 32'(st));
      chk({tag, "_swap"}, 32'(swap_out), 32'(sw));
      chk({tag, "_busy"}, 32'(busy_out), 32'(bz));
      chk({tag, "_gen"}, 32'(gen_count_out), g);
   endtask

   initial begin
      // reset state
      repeat (2) @(posedge clk_in);
      #1;
      outs("rst", 1'b0, 1'b0, 1'b0, 0);
      chk("rst_err", 32'(err_out), 0);
      rst_in = 1'b1;
      idle(2);
      outs("post_rst", 1'b0, 1'b0, 1'b0, 0);

      // single step: start t+1, done t+20, vsync t+40, swap t+41
      cyc(1'b1, 1'b0, 1'b0);
      outs("step_t1", 1'b1, 1'b0, 1'b1, 0);
      idle(1);
      outs("step_t2", 1'b0, 1'b0, 1'b1, 0);
      idle(18);
      cyc(1'b0, 1'b0, 1'b1);
      outs("step_done", 1'b0, 1'b0, 1'b1, 0);
      idle(19);
      outs("step_t40", 1'b0, 1'b0, 1'b1, 0);
      cyc(1'b0, 1'b1, 1'b0);
      outs("step_t41", 1'b0, 1'b1, 1'b1, 1);
      idle(1);
      outs("step_t42", 1'b0, 1'b0, 1'b0, 1);

      // step ignored in COMPUTE and WAIT_FRAME
      cyc(1'b1, 1'b0, 1'b0);
      outs("ign_launch", 1'b1, 1'b0, 1'b1, 1);
      cyc(1'b1, 1'b0, 1'b0);
      outs("ign_comp", 1'b0, 1'b0, 1'b1, 1);
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b0);
      outs("ign_wait", 1'b0, 1'b0, 1'b1, 1);
      cyc(1'b0, 1'b1, 1'b0);
      outs("ign_swap", 1'b0, 1'b1, 1'b1, 2);
      idle(1);
      outs("ign_end", 1'b0, 1'b0, 1'b0, 2);

      // done and vsync together: swap waits for next vsync
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b1);
      outs("dv_same", 1'b0, 1'b0, 1'b1, 2);
      idle(3);
      outs("dv_wait", 1'b0, 1'b0, 1'b1, 2);
      cyc(1'b0, 1'b1, 1'b0);
      outs("dv_swap", 1'b0, 1'b1, 1'b1, 3);
      idle(1);

      // done outside COMPUTE does nothing
      cyc(1'b0, 1'b0, 1'b1);
      outs("done_idle", 1'b0, 1'b0, 1'b0, 3);
      cyc(1'b0, 1'b1, 1'b0);
      outs("vs_idle", 1'b0, 1'b0, 1'b0, 3);

      // free-run, divide by 3
      run_in       = 1'b1;
      frame_div_in = 4'd3;
      cyc(1'b0, 1'b1, 1'b0);
      outs("fr_v1", 1'b0, 1'b0, 1'b0, 3);
      idle(3);
      cyc(1'b0, 1'b1, 1'b0);
      outs("fr_v2", 1'b0, 1'b0, 1'b0, 3);
      idle(3);
      cyc(1'b0, 1'b1, 1'b0);
      outs("fr_v3", 1'b1, 1'b0, 1'b1, 3);
      cyc(1'b0, 1'b0, 1'b1);
      idle(2);
      cyc(1'b0, 1'b1, 1'b0);
      outs("fr_v4", 1'b0, 1'b1, 1'b1, 4);
      idle(3);
      cyc(1'b0, 1'b1, 1'b0);
      outs("fr_v5", 1'b0, 1'b0, 1'b0, 4);
      idle(3);
      cyc(1'b0, 1'b1, 1'b0);
      outs("fr_v6", 1'b0, 1'b0, 1'b0, 4);
      idle(3);
      cyc(1'b0, 1'b1, 1'b0);
      outs("fr_v7", 1'b1, 1'b0, 1'b1, 4);
      cyc(1'b0, 1'b0, 1'b1);
      idle(2);
      cyc(1'b0, 1'b1, 1'b0);
      outs("fr_v8", 1'b0, 1'b1, 1'b1, 5);
      idle(3);

      // divider 0 behaves as 1
      frame_div_in = 4'd0;
      cyc(1'b0, 1'b1, 1'b0);
      outs("div0_v1", 1'b1, 1'b0, 1'b1, 5);
      cyc(1'b0, 1'b0, 1'b1);
      idle(2);
      cyc(1'b0, 1'b1, 1'b0);
      outs("div0_v2", 1'b0, 1'b1, 1'b1, 6);
      idle(3);

      // run dropped mid-generation: completes, no relaunch
      cyc(1'b0, 1'b1, 1'b0);
      outs("rdrop_go", 1'b1, 1'b0, 1'b1, 6);
      run_in = 1'b0;
      cyc(1'b0, 1'b0, 1'b1);
      idle(2);
      cyc(1'b0, 1'b1, 1'b0);
      outs("rdrop_swap", 1'b0, 1'b1, 1'b1, 7);
      idle(3);
      cyc(1'b0, 1'b1, 1'b0);
      outs("rdrop_none", 1'b0, 1'b0, 1'b0, 7);
      idle(1);

      // step and run launch in same cycle: one launch
      run_in = 1'b1;
      cyc(1'b1, 1'b1, 1'b0);
      outs("both_go", 1'b1, 1'b0, 1'b1, 7);
      run_in = 1'b0;
      idle(1);
      outs("both_once", 1'b0, 1'b0, 1'b1, 7);
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 1'b0);
      outs("both_swap", 1'b0, 1'b1, 1'b1, 8);
      idle(1);

      // counter wraps 15 -> 0
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 1'b0, 1'b0);
         cyc(1'b0, 1'b0, 1'b1);
         cyc(1'b0, 1'b1, 1'b0);
         chk("wrap_gen", 32'(gen_count_out), 32'((9 + i) % 16));
         idle(1);
      end

`ifdef GEN_WATCHDOG_EN
      cyc(1'b1, 1'b0, 1'b0);
      idle(15);
      outs("wd_pre", 1'b0, 1'b0, 1'b1, 0);
      chk("wd_pre_err", 32'(err_out), 0);
      idle(1);
      outs("wd_trip", 1'b0, 1'b0, 1'b0, 0);
      chk("wd_trip_err", 32'(err_out), 1);
      cyc(1'b0, 1'b1, 1'b0);
      outs("wd_noswap", 1'b0, 1'b0, 1'b0, 0);
      cyc(1'b1, 1'b0, 1'b0);
      outs("wd_relaunch", 1'b1, 1'b0, 1'b1, 0);
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 1'b0);
      outs("wd_swap", 1'b0, 1'b1, 1'b1, 1);
      chk("wd_sticky", 32'(err_out), 1);
      idle(1);
`else
      cyc(1'b1, 1'b0, 1'b0);
      idle(20);
      outs("nowd_wait", 1'b0, 1'b0, 1'b1, 0);
      chk("nowd_err", 32'(err_out), 0);
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 1'b0);
      outs("nowd_swap", 1'b0, 1'b1, 1'b1, 1);
      idle(1);
`endif

      // async reset mid-COMPUTE, no swap for aborted generation
      cyc(1'b1, 1'b0, 1'b0);
      idle(2);
      #2;
      rst_in = 1'b0;
      #1;
      outs("arst", 1'b0, 1'b0, 1'b0, 0);
      chk("arst_err", 32'(err_out), 0);
      #2;
      rst_in = 1'b1;
      @(posedge clk_in);
      #1;
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 1'b0);
      outs("arst_noswap", 1'b0, 1'b0, 1'b0, 0);
      idle(1);
      outs("arst_idle", 1'b0, 1'b0, 1'b0, 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
